// File: rtl/snes_pad_pkg.sv
// snes_pad_pkg
// Shared constants for the SNES pad responder:
//   - button bit indices inside the 12-bit button vectors (B = bit 0)
//   - frame length of one serial read (16 bits) and the per-port counter width
//   - load_word(): builds the active-low shift-register image for one latch
package snes_pad_pkg;

   localparam int BTN_W     = 12;
   localparam int FRAME_LEN = 16;
   localparam int CNT_W     = 5;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   // The ID goes out MSB first in serial bits 12..15, so it is bit-reversed
   // into the top nibble. The whole word is inverted: the wire is active-low.
   function automatic logic [FRAME_LEN-1:0] load_word(input logic [3:0]       id,
                                                      input logic [BTN_W-1:0] btn);
      return ~{id[0], id[1], id[2], id[3], btn};
   endfunction

endpackage

// File: rtl/snes_pad_port.sv
// snes_pad_port
// One controller port: optional 2-sample filter and rise detection on the
// port shift clock, 16-bit shift register, saturating bit counter, data out.
// Ports:
//   clk_i    : module clock
//   rst_n_i  : synchronous active-low reset
//   strb_i   : filtered latch level from the top (shared by both ports)
//   jclk_i   : raw per-port shift clock from the console
//   btn_i    : active-high button state, B = bit 0
//   conn_i   : pad present
//   di_o     : serial data to the console, active-low, bit 1 tied high
module snes_pad_port
   import snes_pad_pkg::*;
#(
   parameter logic [3:0] PAD_ID = 4'h0,
   parameter bit         FILTER = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             strb_i,
   input  logic             jclk_i,
   input  logic [BTN_W-1:0] btn_i,
   input  logic             conn_i,
   output logic [1:0]       di_o
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

   logic                 smp_q, smp_d;
   logic                 flt_q, flt_d;
   logic                 prev_q;
   logic                 jclk_f;
   logic                 rise;
   logic [FRAME_LEN-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // The filtered level only follows the input once two consecutive samples agree,
   // so a single-cycle glitch never reaches the edge detector.
   always_comb begin
      smp_d = jclk_i;
      flt_d = flt_q;
      if (jclk_i == smp_q) flt_d = jclk_i;
   end

   assign jclk_f = FILTER ? flt_q : jclk_i;
   assign rise   = jclk_f & ~prev_q;

   // Priority: absent pad > latch load > shift. Once the counter reaches the
   // frame length the register is all zeros and further clocks are ignored.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (!conn_i) begin
         sr_d  = '1;
         cnt_d = CNT_FULL;
      end else if (strb_i) begin
         sr_d  = load_word(PAD_ID, btn_i);
         cnt_d = '0;
      end else if (rise && (cnt_q != CNT_FULL)) begin
         sr_d  = {1'b0, sr_q[FRAME_LEN-1:1]};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         smp_q  <= 1'b0;
         flt_q  <= 1'b0;
         prev_q <= 1'b0;
         sr_q   <= '1;
         cnt_q  <= CNT_FULL;
      end else begin
         smp_q  <= smp_d;
         flt_q  <= flt_d;
         prev_q <= jclk_f;
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign di_o = conn_i ? {1'b1, sr_q[0]} : 2'b11;

endmodule

// File: rtl/snes_pad_responder.sv
// snes_pad_responder
// Emulates two SNES controllers answering the console's serial protocol.
// Ports:
//   MCLK               : single clock
//   RESET_N            : synchronous active-low reset
//   JOY_STRB           : latch from the console, shared by both ports
//   JOY1_CLK, JOY2_CLK : per-port shift clocks
//   PAD1_BTN, PAD2_BTN : 12-bit active-high button state (B = bit 0)
//   PAD1_CONN, PAD2_CONN : pad present
//   JOY1_DI, JOY2_DI   : serial data to the console (active-low, bit 1 = 1)
//   LATCH_CNT          : completed latches, wrapping at 256
module snes_pad_responder
   import snes_pad_pkg::*;
#(
   parameter logic [3:0] PAD_ID = 4'h0,
   parameter bit         FILTER = 1'b1
) (
   input  logic             MCLK,
   input  logic             RESET_N,
   input  logic             JOY_STRB,
   input  logic             JOY1_CLK,
   input  logic             JOY2_CLK,
   input  logic [BTN_W-1:0] PAD1_BTN,
   input  logic [BTN_W-1:0] PAD2_BTN,
   input  logic             PAD1_CONN,
   input  logic             PAD2_CONN,
   output logic [1:0]       JOY1_DI,
   output logic [1:0]       JOY2_DI,
   output logic [7:0]       LATCH_CNT
);

   logic       strb_smp_q, strb_smp_d;
   logic       strb_flt_q, strb_flt_d;
   logic       strb_prev_q;
   logic       strb_f;
   logic       strb_fall;
   logic [7:0] latch_cnt_q, latch_cnt_d;

   // Same 2-sample filter as the port clocks, so latch and shift clocks see
   // identical latency and their relative order is preserved.
   always_comb begin
      strb_smp_d = JOY_STRB;
      strb_flt_d = strb_flt_q;
      if (JOY_STRB == strb_smp_q) strb_flt_d = JOY_STRB;
   end

   assign strb_f      = FILTER ? strb_flt_q : JOY_STRB;
   assign strb_fall   = ~strb_f & strb_prev_q;
   assign latch_cnt_d = strb_fall ? latch_cnt_q + 8'd1 : latch_cnt_q;

   always_ff @(posedge MCLK) begin
      if (!RESET_N) begin
         strb_smp_q  <= 1'b0;
         strb_flt_q  <= 1'b0;
         strb_prev_q <= 1'b0;
         latch_cnt_q <= 8'd0;
      end else begin
         strb_smp_q  <= strb_smp_d;
         strb_flt_q  <= strb_flt_d;
         strb_prev_q <= strb_f;
         latch_cnt_q <= latch_cnt_d;
      end
   end

   assign LATCH_CNT = latch_cnt_q;

   snes_pad_port #(.PAD_ID(PAD_ID), .FILTER(FILTER)) u_port1 (
      .clk_i   (MCLK),
      .rst_n_i (RESET_N),
      .strb_i  (strb_f),
      .jclk_i  (JOY1_CLK),
      .btn_i   (PAD1_BTN),
      .conn_i  (PAD1_CONN),
      .di_o    (JOY1_DI)
   );

   snes_pad_port #(.PAD_ID(PAD_ID), .FILTER(FILTER)) u_port2 (
      .clk_i   (MCLK),
      .rst_n_i (RESET_N),
      .strb_i  (strb_f),
      .jclk_i  (JOY2_CLK),
      .btn_i   (PAD2_BTN),
      .conn_i  (PAD2_CONN),
      .di_o    (JOY2_DI)
   );

endmodule
